// File: rtl/pe_id_scan_loader.sv
// ID table plus scan sequencer. It loads per-PE X IDs, per-row Y IDs and the
// LN setting into the PE array, then raises a one-cycle done.
module pe_id_scan_loader #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_ID_wen,
  input  logic [2:0]             ctrl_ID_wsel,
  input  logic [5:0]             ctrl_ID_widx,
  input  logic [4:0]             ctrl_ID_wdata,
  input  logic [NUMS_PE_ROW-2:0] LN_config,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   set_XID,
  output logic [XID_BITS-1:0]    ifmap_XID_scan_in,
  output logic [XID_BITS-1:0]    filter_XID_scan_in,
  output logic [XID_BITS-1:0]    ipsum_XID_scan_in,
  output logic [XID_BITS-1:0]    opsum_XID_scan_in,
  output logic                   set_YID,
  output logic [YID_BITS-1:0]    ifmap_YID_scan_in,
  output logic [YID_BITS-1:0]    filter_YID_scan_in,
  output logic [YID_BITS-1:0]    ipsum_YID_scan_in,
  output logic [YID_BITS-1:0]    opsum_YID_scan_in,
  output logic                   set_LN,
  output logic [NUMS_PE_ROW-2:0] LN_config_in
);

  localparam int NX     = NUMS_PE_ROW * NUMS_PE_COL;
  localparam int XIDX_W = (NX > 1) ? $clog2(NX) : 1;
  localparam int YIDX_W = (NUMS_PE_ROW > 1) ? $clog2(NUMS_PE_ROW) : 1;
  localparam int CNT_W  = XIDX_W;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(NX - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(NUMS_PE_ROW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XID,
    S_YID,
    S_LN,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       cntDec;
  logic [NUMS_PE_ROW-2:0] lnCap_q;

  logic [XID_BITS-1:0] xidTable_q [4][NX];
  logic [XID_BITS-1:0] xidTable_d [4][NX];
  logic [YID_BITS-1:0] yidTable_q [4][NUMS_PE_ROW];
  logic [YID_BITS-1:0] yidTable_d [4][NUMS_PE_ROW];

  logic                   busy_q;
  logic                   done_q;
  logic                   setXid_q;
  logic                   setYid_q;
  logic                   setLn_q;
  logic [XID_BITS-1:0]    xidOut_q [4];
  logic [YID_BITS-1:0]    yidOut_q [4];
  logic [NUMS_PE_ROW-2:0] lnOut_q;

  logic              wrOpen;
  logic              wrX;
  logic              wrY;
  logic [1:0]        wrTag;
  logic [XIDX_W-1:0] wrXIdx;
  logic [YIDX_W-1:0] wrYIdx;

  assign wrOpen = ctrl_ID_wen && (state_q == S_IDLE);
  assign wrX    = wrOpen && !ctrl_ID_wsel[2] && (int'(ctrl_ID_widx) < NX);
  assign wrY    = wrOpen &&  ctrl_ID_wsel[2] && (int'(ctrl_ID_widx) < NUMS_PE_ROW);
  assign wrTag  = ctrl_ID_wsel[1:0];
  assign wrXIdx = ctrl_ID_widx[XIDX_W-1:0];
  assign wrYIdx = ctrl_ID_widx[YIDX_W-1:0];
  assign cntDec = count_q - 1'b1;

  // The start cycle reads the _d view so a write in that same cycle is shifted out.
  always_comb begin
    xidTable_d = xidTable_q;
    yidTable_d = yidTable_q;
    if (wrX) begin
      xidTable_d[wrTag][wrXIdx] = ctrl_ID_wdata[XID_BITS-1:0];
    end
    if (wrY) begin
      yidTable_d[wrTag][wrYIdx] = ctrl_ID_wdata[YID_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xidTable_q <= '{default: '0};
      yidTable_q <= '{default: '0};
    end else begin
      xidTable_q <= xidTable_d;
      yidTable_q <= yidTable_d;
    end
  end

  // Strobes and data default to zero each cycle, so scan buses idle at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      lnCap_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      setXid_q <= 1'b0;
      setYid_q <= 1'b0;
      setLn_q  <= 1'b0;
      xidOut_q <= '{default: '0};
      yidOut_q <= '{default: '0};
      lnOut_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      setXid_q <= 1'b0;
      setYid_q <= 1'b0;
      setLn_q  <= 1'b0;
      xidOut_q <= '{default: '0};
      yidOut_q <= '{default: '0};
      lnOut_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_XID;
            count_q  <= X_LAST;
            lnCap_q  <= LN_config;
            busy_q   <= 1'b1;
            setXid_q <= 1'b1;
            for (int t = 0; t < 4; t++) begin
              xidOut_q[t] <= xidTable_d[t][X_LAST];
            end
          end
        end
        S_XID: begin
          if (count_q == '0) begin
            state_q  <= S_YID;
            count_q  <= Y_LAST;
            setYid_q <= 1'b1;
            for (int t = 0; t < 4; t++) begin
              yidOut_q[t] <= yidTable_q[t][Y_LAST[YIDX_W-1:0]];
            end
          end else begin
            count_q  <= cntDec;
            setXid_q <= 1'b1;
            for (int t = 0; t < 4; t++) begin
              xidOut_q[t] <= xidTable_q[t][cntDec];
            end
          end
        end
        S_YID: begin
          if (count_q == '0) begin
            state_q <= S_LN;
            setLn_q <= 1'b1;
            lnOut_q <= lnCap_q;
          end else begin
            count_q  <= cntDec;
            setYid_q <= 1'b1;
            for (int t = 0; t < 4; t++) begin
              yidOut_q[t] <= yidTable_q[t][cntDec[YIDX_W-1:0]];
            end
          end
        end
        S_LN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign set_XID            = setXid_q;
  assign set_YID            = setYid_q;
  assign set_LN             = setLn_q;
  assign ifmap_XID_scan_in  = xidOut_q[0];
  assign filter_XID_scan_in = xidOut_q[1];
  assign ipsum_XID_scan_in  = xidOut_q[2];
  assign opsum_XID_scan_in  = xidOut_q[3];
  assign ifmap_YID_scan_in  = yidOut_q[0];
  assign filter_YID_scan_in = yidOut_q[1];
  assign ipsum_YID_scan_in  = yidOut_q[2];
  assign opsum_YID_scan_in  = yidOut_q[3];
  assign LN_config_in       = lnOut_q;

endmodule
